// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared helpers for the 2x2 stride-2 max-pool stage.
// Provides the counter/address width function.
package maxpool_2x2_stream_pkg;

    // Bits needed to index n items. Never returns less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/maxpool_max2.sv
// Combinational 2-input maximum, signed or unsigned.
// Ports: a, b operands; y = larger of the two.
module maxpool_max2
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int Datawidth = 32,
    parameter int SIGNED    = 1
) (
    input  logic [Datawidth-1:0] a,
    input  logic [Datawidth-1:0] b,
    output logic [Datawidth-1:0] y
);

    logic a_gt;

    always_comb begin
        a_gt = 1'b0;
        if (SIGNED != 0) begin
            a_gt = $signed(a) > $signed(b);
        end else begin
            a_gt = a > b;
        end
        y = a_gt ? a : b;
    end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster pixel stream.
// Ports: clk, rst (async high), valid_in/In pixel stream,
// valid_out/Out pooled pixel, out_last on the final pooled pixel.
module maxpool_2x2_stream
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int IMG_Width  = 4,
    parameter int IMG_Height = 4,
    parameter int Datawidth  = 32,
    parameter int SIGNED     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In,
    output logic                 valid_out,
    output logic [Datawidth-1:0] Out,
    output logic                 out_last
);

    localparam int PW    = IMG_Width / 2;
    localparam int PH    = IMG_Height / 2;
    localparam int COL_W = clog2(IMG_Width);
    localparam int ROW_W = clog2(IMG_Height);
    localparam int LB_AW = clog2(PW);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_Width - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_Height - 1);
    // Last column/row that belongs to a complete window.
    localparam logic [COL_W-1:0] COL_END = COL_W'(2 * PW - 1);
    localparam logic [ROW_W-1:0] ROW_END = ROW_W'(2 * PH - 1);

    if (IMG_Width < 2 || IMG_Height < 2) begin : g_param_err
        $error("maxpool_2x2_stream: IMG_Width and IMG_Height must be >= 2");
    end

    logic [COL_W-1:0]     col_cnt;
    logic [ROW_W-1:0]     row_cnt;
    logic [Datawidth-1:0] pair_reg;
    logic [Datawidth-1:0] line_buf [PW];
    logic [LB_AW-1:0]     lb_idx;
    logic [Datawidth-1:0] lb_rd;
    logic [Datawidth-1:0] hmax;
    logic [Datawidth-1:0] vmax;
    logic                 in_win;
    logic                 take;
    logic                 col_wrap;
    logic                 row_wrap;

    assign col_wrap = (col_cnt == COL_MAX);
    assign row_wrap = (row_cnt == ROW_MAX);
    // Trailing odd column/row never reaches a complete window.
    assign in_win   = (col_cnt <= COL_END) && (row_cnt <= ROW_END);
    // A window's right-hand pixel completes a horizontal pair.
    assign take     = valid_in && col_cnt[0] && in_win;
    assign lb_idx   = LB_AW'(col_cnt >> 1);
    assign lb_rd    = line_buf[lb_idx];

    maxpool_max2 #(
        .Datawidth (Datawidth),
        .SIGNED    (SIGNED)
    ) u_hmax (
        .a (pair_reg),
        .b (In),
        .y (hmax)
    );

    maxpool_max2 #(
        .Datawidth (Datawidth),
        .SIGNED    (SIGNED)
    ) u_vmax (
        .a (hmax),
        .b (lb_rd),
        .y (vmax)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_in) begin
            if (col_wrap) begin
                col_cnt <= '0;
                row_cnt <= row_wrap ? '0 : row_cnt + ROW_W'(1);
            end else begin
                col_cnt <= col_cnt + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_reg <= '0;
        end else if (valid_in && !col_cnt[0]) begin
            pair_reg <= In;
        end
    end

    // Always written on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (take && !row_cnt[0]) begin
            line_buf[lb_idx] <= hmax;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out       <= '0;
            valid_out <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            valid_out <= take && row_cnt[0];
            out_last  <= take && row_cnt[0] &&
                         (col_cnt == COL_END) &&
                         (row_cnt == ROW_END);
            if (take && row_cnt[0]) begin
                Out <= vmax;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Scoreboard bench for maxpool_2x2_stream across several sizes.
// Expected windows are computed from whole frames held in the bench.
module tb_maxpool_2x2_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin;
    logic [31:0] din;
    int          sel;
    logic [3:0]  vo;
    logic [3:0]  lo;
    logic [31:0] dout [4];
    logic [31:0] held [4];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    maxpool_2x2_stream #(
        .IMG_Width(4), .IMG_Height(4), .Datawidth(32), .SIGNED(1)
    ) u0 (
        .clk(clk), .rst(rst), .valid_in(vin && sel == 0), .In(din),
        .valid_out(vo[0]), .Out(dout[0]), .out_last(lo[0])
    );

    maxpool_2x2_stream #(
        .IMG_Width(2), .IMG_Height(2), .Datawidth(32), .SIGNED(1)
    ) u1 (
        .clk(clk), .rst(rst), .valid_in(vin && sel == 1), .In(din),
        .valid_out(vo[1]), .Out(dout[1]), .out_last(lo[1])
    );

    maxpool_2x2_stream #(
        .IMG_Width(2), .IMG_Height(2), .Datawidth(32), .SIGNED(0)
    ) u2 (
        .clk(clk), .rst(rst), .valid_in(vin && sel == 2), .In(din),
        .valid_out(vo[2]), .Out(dout[2]), .out_last(lo[2])
    );

    maxpool_2x2_stream #(
        .IMG_Width(5), .IMG_Height(3), .Datawidth(32), .SIGNED(1)
    ) u3 (
        .clk(clk), .rst(rst), .valid_in(vin && sel == 3), .In(din),
        .valid_out(vo[3]), .Out(dout[3]), .out_last(lo[3])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mx(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input bit sgn);
        if (sgn) return ($signed(a) > $signed(b)) ? a : b;
        return (a > b) ? a : b;
    endfunction

    task automatic drive_frame(input int k, input logic [31:0] px[$],
                               input int w, input int h,
                               input int npix, input int gapmax);
        bit sgn;
        int pw;
        int ph;
        sgn = (k != 2);
        pw  = w / 2;
        ph  = h / 2;
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            int g;
            exp_t e;
            r = i / w;
            c = i % w;
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                vin = 1'b0;
            end
            @(negedge clk);
            sel = k;
            vin = 1'b1;
            din = px[i];
            if (r % 2 == 1 && c % 2 == 1 && r < 2 * ph && c < 2 * pw) begin
                e.d = mx(mx(px[i-w-1], px[i-w], sgn),
                         mx(px[i-1], px[i], sgn), sgn);
                e.l = (r == 2 * ph - 1) && (c == 2 * pw - 1);
                e.c = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        vin = 1'b0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                held[k] = '0;
                check("rst_out", dout[k], 32'd0);
                check("rst_vo", 32'(vo[k]), 32'd0);
                check("rst_last", 32'(lo[k]), 32'd0);
            end else if (vo[k]) begin
                if (k != sel || exp_q.size() == 0) begin
                    check("spurious", 32'(vo[k]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out", dout[k], e.d);
                    check("last", 32'(lo[k]), 32'(e.l));
                    check("latency", cyc, e.c);
                end
                held[k] = dout[k];
            end else begin
                check("hold", dout[k], held[k]);
                check("last_low", 32'(lo[k]), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] f[$];
        logic [31:0] fr[$];
        logic [31:0] f2[$];
        logic [31:0] f3[$];

        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            f.push_back(32'(i + 1));
            fr.push_back(32'(16 - i));
        end
        for (int i = 0; i < 15; i++) f3.push_back(32'(i + 1));
        f2 = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF7};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        drive_frame(0, f, 4, 4, 16, 0);
        drain();
        drive_frame(0, f, 4, 4, 16, 3);
        drain();

        drive_frame(1, f2, 2, 2, 4, 0);
        drain();
        drive_frame(2, f2, 2, 2, 4, 2);
        drain();

        drive_frame(3, f3, 5, 3, 15, 0);
        drive_frame(3, f3, 5, 3, 15, 1);
        drain();

        drive_frame(0, f, 4, 4, 5, 0);
        @(negedge clk);
        vin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_out", dout[0], 32'd0);
        check("async_vo", 32'(vo[0]), 32'd0);
        check("async_last", 32'(lo[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_frame(0, f, 4, 4, 16, 0);
        drain();

        drive_frame(0, f, 4, 4, 16, 0);
        drive_frame(0, fr, 4, 4, 16, 0);
        drain();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
